cic_interpolator: RTL

//  N-stage CIC interpolator, the TX-side counterpart of the CIC decimator.

---
 rtl/cic_interpolator.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/cic_interpolator.sv
// N-stage CIC interpolator: low-rate comb chain, zero-stuff by R, high-rate integrator chain.
// Define CIC_INTERP_ROUND_EN for round-half-up output with positive saturation (default: MSB truncation).
module cic_interpolator #(
    parameter int IW = 16,
    parameter int OW = 25,
    parameter int R  = 8,
    parameter int N  = 3,
    parameter int M  = 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_ce,
    input  logic          i_valid,
    input  logic [IW-1:0] i_data,
    output logic          o_ready,
    output logic [OW-1:0] o_data,
    output logic          o_valid,
    output logic          o_underrun
);

    localparam int AW = IW + N * $clog2(R * M);
    localparam int PW = $clog2(R);

`ifdef CIC_INTERP_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    generate
        if (OW > AW) begin : g_bad_ow
            $error("cic_interpolator: OW must not exceed AW");
        end
        if (R < 2) begin : g_bad_r
            $error("cic_interpolator: R must be at least 2");
        end
        if (N < 1) begin : g_bad_n
            $error("cic_interpolator: N must be at least 1");
        end
        if (M != 1 && M != 2) begin : g_bad_m
            $error("cic_interpolator: M must be 1 or 2");
        end
    endgenerate

    logic [PW-1:0] phase_q, phase_d;
    logic          full_q, full_d;
    logic [IW-1:0] hold_q, hold_d;
    logic [AW-1:0] comb_q  [N];
    logic [AW-1:0] comb_d  [N];
    logic [AW-1:0] dly_q   [N][M];
    logic [AW-1:0] dly_d   [N][M];
    logic [AW-1:0] integ_q [N];
    logic [AW-1:0] integ_d [N];
    logic [OW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic          underrun_q, underrun_d;

    logic          load_tick;
    logic          accept;
    logic [AW-1:0] comb_in;
    logic [AW-1:0] upsample;
    logic [OW-1:0] out_fmt;

    assign load_tick = i_ce & (phase_q == '0);
    assign o_ready   = ~full_q | load_tick;
    assign accept    = i_valid & o_ready;
    // An empty hold register at a load tick feeds a zero sample into the combs.
    assign comb_in   = full_q ? {{(AW-IW){hold_q[IW-1]}}, hold_q} : '0;
    assign upsample  = (phase_q == '0) ? comb_q[N-1] : '0;

    generate
        if (ROUND_EN && (AW > OW)) begin : g_round
            localparam int            SH     = AW - OW;
            localparam logic [AW-1:0] HALF   = AW'(1) << (SH - 1);
            localparam logic [AW-1:0] SAT_TH = {1'b0, {(AW-1){1'b1}}} - HALF + AW'(1);
            assign out_fmt = ($signed(integ_q[N-1]) >= $signed(SAT_TH))
                           ? {1'b0, {(OW-1){1'b1}}}
                           : OW'((integ_q[N-1] + HALF) >> SH);
        end else begin : g_trunc
            assign out_fmt = integ_q[N-1][AW-1 -: OW];
        end
    endgenerate

    always_comb begin
        phase_d    = phase_q;
        full_d     = full_q;
        hold_d     = hold_q;
        comb_d     = comb_q;
        dly_d      = dly_q;
        integ_d    = integ_q;
        data_d     = data_q;
        valid_d    = i_ce;
        underrun_d = load_tick & ~full_q;

        // A load tick and a new accept in the same cycle refill the hold register.
        if (accept) begin
            hold_d = i_data;
            full_d = 1'b1;
        end else if (load_tick) begin
            full_d = 1'b0;
        end

        if (load_tick) begin
            comb_d[0]    = comb_in - dly_q[0][M-1];
            dly_d[0][0]  = comb_in;
            for (int k = 1; k < N; k++) begin
                comb_d[k]   = comb_q[k-1] - dly_q[k][M-1];
                dly_d[k][0] = comb_q[k-1];
            end
            for (int k = 0; k < N; k++) begin
                for (int m = 1; m < M; m++) begin
                    dly_d[k][m] = dly_q[k][m-1];
                end
            end
        end

        if (i_ce) begin
            phase_d    = (phase_q == PW'(R - 1)) ? '0 : phase_q + 1'b1;
            integ_d[0] = integ_q[0] + upsample;
            for (int k = 1; k < N; k++) begin
                integ_d[k] = integ_q[k] + integ_q[k-1];
            end
            data_d = out_fmt;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            phase_q    <= '0;
            full_q     <= 1'b0;
            hold_q     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            underrun_q <= 1'b0;
            for (int k = 0; k < N; k++) begin
                comb_q[k]  <= '0;
                integ_q[k] <= '0;
                for (int m = 0; m < M; m++) begin
                    dly_q[k][m] <= '0;
                end
            end
        end else begin
            phase_q    <= phase_d;
            full_q     <= full_d;
            hold_q     <= hold_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            underrun_q <= underrun_d;
            comb_q     <= comb_d;
            integ_q    <= integ_d;
            dly_q      <= dly_d;
        end
    end

    assign o_data     = data_q;
    assign o_valid    = valid_q;
    assign o_underrun = underrun_q;

endmodule
